// File: rtl/sha256_nonce_dispatcher_if.sv
// rtl/sha256_nonce_dispatcher_if.sv - worker array handshake and result memory write port
interface sha256_nonce_dispatcher_if #(
  parameter int NUM_WORKERS = 4
);
  logic [NUM_WORKERS-1:0]    wk_start;
  logic [32*NUM_WORKERS-1:0] wk_nonce;
  logic [NUM_WORKERS-1:0]    wk_done;
  logic [32*NUM_WORKERS-1:0] wk_hash;
  logic                      mem_we;
  logic [15:0]               mem_addr;
  logic [31:0]               mem_write_data;

  modport master (
    output wk_start, wk_nonce, mem_we, mem_addr, mem_write_data,
    input  wk_done, wk_hash
  );

  modport slave (
    input  wk_start, wk_nonce, mem_we, mem_addr, mem_write_data,
    output wk_done, wk_hash
  );
endinterface

// File: rtl/sha256_nonce_dispatcher.sv
// rtl/sha256_nonce_dispatcher.sv - nonce scheduler and H0 writeback for a SHA-256 worker array
// Optional macro TARGET_CMP_EN adds the H0 < target search (found / found_nonce).
module sha256_nonce_dispatcher #(
  parameter int NUM_WORKERS = 4,
  parameter int NUM_NONCE   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [31:0]               nonce_base,
  input  logic [15:0]               output_addr,
  input  logic [31:0]               target,
  output logic                      busy,
  output logic                      done,
  sha256_nonce_dispatcher_if.master bus,
  output logic                      found,
  output logic [31:0]               found_nonce
);
  localparam int WW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {W_FREE, W_RUN, W_HOLD} wstate_t;

  state_t        state;
  wstate_t       ws  [NUM_WORKERS];
  logic [15:0]   idx [NUM_WORKERS];
  logic [31:0]   res [NUM_WORKERS];
  logic [31:0]   base_q;
  logic [15:0]   oaddr_q;
  logic [16:0]   issue_cnt;
  logic [16:0]   wr_cnt;
  logic [WW-1:0] last_wr;

  logic          iss_en;
  logic [WW-1:0] iss_sel;
  logic          wr_en;
  logic [WW-1:0] wr_sel;

  // Issue: lowest FREE worker. Write: first HOLD worker after the last one written.
  always_comb begin
    int j;
    j       = 0;
    iss_en  = 1'b0;
    iss_sel = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (ws[i] == W_FREE) begin
        iss_en  = 1'b1;
        iss_sel = WW'(i);
      end
    end
    iss_en = iss_en && (state == S_RUN) && (issue_cnt < 17'(NUM_NONCE));

    wr_en  = 1'b0;
    wr_sel = '0;
    for (int k = NUM_WORKERS; k >= 1; k--) begin
      j = (int'(last_wr) + k) % NUM_WORKERS;
      if (ws[j] == W_HOLD) begin
        wr_en  = 1'b1;
        wr_sel = WW'(j);
      end
    end
    wr_en = wr_en && (state == S_RUN);
  end

  // Outputs decode registered state only; a worker's nonce stays visible after its start.
  always_comb begin
    bus.wk_start       = '0;
    bus.wk_nonce       = '0;
    bus.mem_we         = wr_en;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      bus.wk_nonce[32*i +: 32] = base_q + {16'h0000, idx[i]};
      if (iss_en && (iss_sel == WW'(i))) begin
        bus.wk_start[i]          = 1'b1;
        bus.wk_nonce[32*i +: 32] = base_q + 32'(issue_cnt);
      end
      if (wr_en && (wr_sel == WW'(i))) begin
        bus.mem_addr       = oaddr_q + idx[i];
        bus.mem_write_data = res[i];
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      base_q    <= '0;
      oaddr_q   <= '0;
      issue_cnt <= '0;
      wr_cnt    <= '0;
      last_wr   <= WW'(NUM_WORKERS - 1);
      for (int i = 0; i < NUM_WORKERS; i++) begin
        ws[i]  <= W_FREE;
        idx[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            base_q    <= nonce_base;
            oaddr_q   <= output_addr;
            issue_cnt <= '0;
            wr_cnt    <= '0;
          end
        end
        S_RUN: begin
          if (wr_cnt == 17'(NUM_NONCE)) state <= S_FIN;
          for (int i = 0; i < NUM_WORKERS; i++) begin
            if (bus.wk_done[i] && (ws[i] == W_RUN)) begin
              ws[i]  <= W_HOLD;
              res[i] <= bus.wk_hash[32*i +: 32];
            end
          end
          // Issue, collect and write always touch different workers in one cycle.
          if (iss_en) begin
            ws[iss_sel]  <= W_RUN;
            idx[iss_sel] <= issue_cnt[15:0];
            issue_cnt    <= issue_cnt + 17'd1;
          end
          if (wr_en) begin
            ws[wr_sel] <= W_FREE;
            last_wr    <= wr_sel;
            wr_cnt     <= wr_cnt + 17'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TARGET_CMP_EN
  logic        found_n;
  logic [15:0] fidx_n;
  logic [15:0] fidx_q;

  // Several captures in one cycle: keep the lowest qualifying index.
  always_comb begin
    found_n = found;
    fidx_n  = fidx_q;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if ((state == S_RUN) && bus.wk_done[i] && (ws[i] == W_RUN) &&
          (bus.wk_hash[32*i +: 32] < target) && (!found_n || (idx[i] < fidx_n))) begin
        found_n = 1'b1;
        fidx_n  = idx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found       <= 1'b0;
      fidx_q      <= '0;
      found_nonce <= '0;
    end else if ((state == S_IDLE) && start) begin
      found       <= 1'b0;
      fidx_q      <= '0;
      found_nonce <= '0;
    end else if (found_n) begin
      found       <= 1'b1;
      fidx_q      <= fidx_n;
      found_nonce <= base_q + {16'h0000, fidx_n};
    end
  end
`else
  logic unused_target;
  assign unused_target = ^target;
  assign found         = 1'b0;
  assign found_nonce   = '0;
`endif
endmodule

// File: tb/tb_sha256_nonce_dispatcher.sv
// tb/tb_sha256_nonce_dispatcher.sv - randomized directed bench with behavioural workers and result model
module tb_sha256_nonce_dispatcher;
  localparam int NW = 4;
  localparam int NN = 16;

  logic        clk         = 1'b0;
  logic        reset_n     = 1'b0;
  logic        start       = 1'b0;
  logic [31:0] nonce_base  = '0;
  logic [15:0] output_addr = '0;
  logic [31:0] target      = '0;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;

  always #5 clk = ~clk;

  sha256_nonce_dispatcher_if #(.NUM_WORKERS(NW)) bus ();

  sha256_nonce_dispatcher #(.NUM_WORKERS(NW), .NUM_NONCE(NN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .nonce_base(nonce_base),
    .output_addr(output_addr), .target(target), .busy(busy), .done(done),
    .bus(bus), .found(found), .found_nonce(found_nonce)
  );

  int          total = 0;
  int          bad   = 0;
  int          lat_w [NW];
  int          slow_idx  = -1;
  int          slow_lat  = 0;
  int          hash_mode = 0;
  logic [31:0] salt      = '0;
  logic [31:0] base_m    = '0;
  logic [15:0] oa_m      = '0;
  logic        clr_req   = 1'b0;
  logic        reissue_chk = 1'b0;
  logic [NW-1:0] spur_done = '0;

  logic [NW-1:0]    done_m = '0;
  logic [32*NW-1:0] hash_m = '0;
  int          cnt_w [NW];
  logic        busy_w [NW];
  logic        hold_w [NW];
  logic        chk_next [NW];
  logic [31:0] nonce_w [NW];
  int          starts_w [NW];
  int          hits [NN];
  logic [31:0] wdata [NN];
  int          owner [NN];
  logic [31:0] iss_q [$];
  int starts_tot = 0, wr_tot = 0, wr_out = 0, viol = 0;
  int reissue_bad = 0, reissue_seen = 0, done_cnt = 0;

  assign bus.wk_done = done_m | spur_done;
  assign bus.wk_hash = hash_m;

  function automatic logic [31:0] model_h0(input logic [31:0] n);
    logic [31:0] k;
    k = n - base_m;
    if (hash_mode == 1)
      return (k == 32'd5 || k == 32'd9) ? (32'h0000_0100 + k) : (32'h8000_0000 | (n ^ salt));
    return (n * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic int lat_of(input int w, input logic [31:0] n);
    if (slow_idx >= 0 && (n - base_m) == 32'(slow_idx)) return slow_lat;
    return lat_w[w];
  endfunction

  // Worker cores and bus monitor, evaluated mid-cycle.
  initial begin
    logic [31:0] k;
    int w;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        done_m = '0;
        hash_m = '0;
        for (int i = 0; i < NW; i++) begin
          busy_w[i] = 1'b0; hold_w[i] = 1'b0; chk_next[i] = 1'b0; cnt_w[i] = 0;
        end
      end else begin
        if (clr_req) begin
          starts_tot = 0; wr_tot = 0; wr_out = 0; viol = 0;
          reissue_bad = 0; reissue_seen = 0; done_cnt = 0;
          iss_q.delete();
          for (int i = 0; i < NW; i++) starts_w[i] = 0;
          for (int n = 0; n < NN; n++) begin hits[n] = 0; wdata[n] = 'x; owner[n] = 0; end
        end
        for (int i = 0; i < NW; i++) begin
          if (chk_next[i]) begin
            reissue_seen++;
            if (!bus.wk_start[i]) reissue_bad++;
            chk_next[i] = 1'b0;
          end
        end
        for (int i = 0; i < NW; i++) begin
          if (bus.wk_start[i]) begin
            if (busy_w[i] || hold_w[i]) viol++;
            starts_w[i]++;
            starts_tot++;
            iss_q.push_back(bus.wk_nonce[32*i +: 32]);
            k = bus.wk_nonce[32*i +: 32] - base_m;
            if (k < NN) owner[k] = i;
          end
        end
        if (bus.mem_we) begin
          wr_tot++;
          if (!busy) wr_out++;
          k = 32'(16'(bus.mem_addr - oa_m));
          if (k < NN) begin
            hits[k]++;
            wdata[k] = bus.mem_write_data;
            w = owner[k];
            hold_w[w] = 1'b0;
            if (reissue_chk && starts_tot < NN) chk_next[w] = 1'b1;
          end else begin
            wr_out++;
          end
        end
        for (int i = 0; i < NW; i++) begin
          done_m[i] = 1'b0;
          hash_m[32*i +: 32] = '0;
          if (busy_w[i]) begin
            cnt_w[i]--;
            if (cnt_w[i] == 0) begin
              busy_w[i] = 1'b0;
              hold_w[i] = 1'b1;
              done_m[i] = 1'b1;
              hash_m[32*i +: 32] = model_h0(nonce_w[i]);
            end
          end
        end
        for (int i = 0; i < NW; i++) begin
          if (bus.wk_start[i]) begin
            busy_w[i]  = 1'b1;
            nonce_w[i] = bus.wk_nonce[32*i +: 32];
            cnt_w[i]   = lat_of(i, bus.wk_nonce[32*i +: 32]);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] oa);
    clear_stats();
    base_m      = b;
    oa_m        = oa;
    salt        = $urandom();
    nonce_base  = b;
    output_addr = oa;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    nonce_base  = $urandom();
    output_addr = 16'($urandom());
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("%s_timeout", tag), 64'(n < 3000), 64'd1);
    repeat (3) tick();
    check($sformatf("%s_done_pulses", tag), 64'(done_cnt), 64'd1);
    check($sformatf("%s_busy_after", tag), 64'(busy), 64'd0);
  endtask

  task automatic verify(input string tag);
    logic        ff;
    logic [31:0] fn;
    for (int n = 0; n < NN; n++) begin
      check($sformatf("%s_hits%0d", tag, n), 64'(hits[n]), 64'd1);
      check($sformatf("%s_data%0d", tag, n), 64'(wdata[n]), 64'(model_h0(base_m + 32'(n))));
    end
    check($sformatf("%s_starts", tag), 64'(starts_tot), 64'(NN));
    check($sformatf("%s_busy_start", tag), 64'(viol), 64'd0);
    check($sformatf("%s_stray_writes", tag), 64'(wr_out), 64'd0);
    ff = 1'b0;
    fn = '0;
`ifdef TARGET_CMP_EN
    for (int n = 0; n < NN; n++) begin
      if (!ff && model_h0(base_m + 32'(n)) < target) begin
        ff = 1'b1;
        fn = base_m + 32'(n);
      end
    end
`endif
    check($sformatf("%s_found", tag), 64'(found), 64'(ff));
    check($sformatf("%s_found_nonce", tag), 64'(found_nonce), 64'(fn));
  endtask

  initial begin
    int n;
    for (int i = 0; i < NW; i++) lat_w[i] = 10;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_wk_start", 64'(bus.wk_start), 64'd0);
    check("rst_wk_nonce", 64'(|bus.wk_nonce), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_found_nonce", 64'(found_nonce), 64'd0);

    // Basic run, fixed latency 10
    target = $urandom();
    launch(32'h0, 16'h0100);
    check("t1_first_start", 64'(bus.wk_start), 64'd1);
    check("t1_first_nonce", 64'(bus.wk_nonce[31:0]), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");
    verify("t1");

    // Skewed latencies
    lat_w[0] = 40; lat_w[1] = 40; lat_w[2] = 40; lat_w[3] = 3;
    launch($urandom(), 16'($urandom()));
    wait_done("t2");
    verify("t2");
    check("t2_w3_share", 64'(starts_w[3] >= 8), 64'd1);

    // Simultaneous completion every round
    lat_w[0] = 13; lat_w[1] = 12; lat_w[2] = 11; lat_w[3] = 10;
    reissue_chk = 1'b1;
    launch($urandom(), 16'($urandom()));
    wait_done("t3");
    verify("t3");
    check("t3_reissue_late", 64'(reissue_bad), 64'd0);
    check("t3_reissue_seen", 64'(reissue_seen), 64'd12);
    reissue_chk = 1'b0;

    // Spurious wk_done in IDLE, then start while busy
    for (int i = 0; i < NW; i++) lat_w[i] = $urandom_range(2, 20);
    clear_stats();
    spur_done = 4'b0100;
    tick();
    spur_done = '0;
    tick();
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_writes", 64'(wr_tot), 64'd0);
    launch($urandom(), 16'($urandom()));
    repeat (6) tick();
    nonce_base = base_m ^ 32'h00FF_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4");
    verify("t4");

    // Reset mid-run, then wrap of the nonce counter
    for (int i = 0; i < NW; i++) lat_w[i] = 10;
    launch($urandom(), 16'($urandom()));
    n = 0;
    while (wr_tot < 5 && n < 500) begin
      tick();
      n++;
    end
    check("t5_five_writes", 64'(n < 500), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("t5_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("t5_rst_mem_data", 64'(bus.mem_write_data), 64'd0);
    check("t5_rst_wk_start", 64'(bus.wk_start), 64'd0);
    check("t5_rst_wk_nonce", 64'(|bus.wk_nonce), 64'd0);
    check("t5_rst_found", 64'(found), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    launch(32'hFFFF_FFFE, 16'($urandom()));
    wait_done("t5");
    verify("t5");
    check("t5_issue_count", 64'(iss_q.size()), 64'(NN));
    if (iss_q.size() >= 3) check("t5_wrap_nonce", 64'(iss_q[2]), 64'd0);

    // Two below-target hashes, the higher index completes first
    hash_mode = 1;
    target    = 32'h0001_0000;
    for (int i = 0; i < NW; i++) lat_w[i] = 4;
    slow_idx  = 5;
    slow_lat  = 60;
    launch($urandom(), 16'($urandom()));
    wait_done("t6");
    verify("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
